mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
Execute-stage controller sitting directly upstream of the iterative 64-bit multiplier. It accepts RV64M multiply ops (MUL/MULH/MULHSU/MULHU/MULW) from the EX issue logic and drives the multiplier's mul_valid/mulw/mul_signed/operand interface. It detects completion from the multiplier's mul_ready handshake, selects and sign-extends the result, and presents it to writeback on a valid/ready port. It also handles pipeline flush at every phase.

Parameters:
XLEN, 64, operand/result width
TAG_W, 5, destination-register tag width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  cancel in-flight op; also wired to multiplier flush
in_valid  in  1  op request valid
in_ready  out  1  controller can accept op
in_op  in  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=MULW (5-7 illegal)
in_src1  in  XLEN  rs1 (multiplicand)
in_src2  in  XLEN  rs2 (multiplier)
in_rd  in  TAG_W  destination tag
mul_valid  out  1  to multiplier
mulw  out  1  to multiplier, 32-bit op
mul_signed  out  2  to multiplier: 11 s*s, 10 s*u, 00 u*u
multiplicand  out  XLEN  to multiplier
multiplier  out  XLEN  to multiplier
mul_ready  in  1  multiplier idle/accepting; rises again when result_hi/lo are valid
result_hi  in  XLEN  from multiplier
result_lo  in  XLEN  from multiplier
out_valid  out  1  result valid to writeback
out_ready  in  1  writeback accepts
out_result  out  XLEN  selected result
out_rd  out  TAG_W  tag of the result

Behaviour:
- Reset: state=IDLE; in_ready=0 during rst, 1 in IDLE afterwards; mul_valid=0, out_valid=0, mulw=0, mul_signed=0, operand/result/tag registers=0.
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE: in_ready=1 (combinational, gated by !flush). in_valid&in_ready latches op/src1/src2/rd, then goes to ISSUE.
- ISSUE: mul_valid=1 with registered operands.
  - Encoding: mulw=1 only for MULW. mul_signed: MUL 11, MULH 11, MULHSU 10, MULHU 00, MULW 11.
  - mul_valid&mul_ready at a rising edge goes to WAIT. Otherwise remain in ISSUE holding all outputs stable.
- WAIT: mul_valid=0. The multiplier registers mul_ready=0 on the accept edge, so the first WAIT cycle always sees mul_ready=0. When mul_ready=1, capture the result and go to DONE.
- Result select: MUL gives result_lo. MULH/MULHSU/MULHU give result_hi. MULW gives sign-extended result_lo[31:0].
- DONE: out_valid=1 with out_result/out_rd held stable until out_ready. On out_valid&out_ready go to IDLE. No new op is accepted in DONE.
- Latency: accept edge t → mul_valid high from t+1. Best case out_valid at t+1+(multiplier cycles)+1.
- Flush (highest priority):
  - IDLE: no accept.
  - ISSUE: go to IDLE, mul_valid drops next cycle.
  - WAIT: go to DRAIN.
  - DRAIN: wait for mul_ready=1, discard result, go to IDLE; in_ready=0 while in DRAIN.
  - DONE: drop out_valid, go to IDLE, result is lost.
  - Flush in DRAIN is a no-op.
- Illegal op (5-7): accepted, never sent to the multiplier, completes via DONE with out_result=0.
- rst mid-operation: immediate return to reset values. The multiplier shares rst, so no drain is needed.

Optional Feature:
MUL_CTRL_REUSE_EN
- Defined:
  - Keep the last completed non-MULW product: hi, lo, src1, src2, mul_signed, and a cache-valid bit.
  - A new MUL, or a MULH* whose mul_signed matches, with identical src1/src2 and cache valid, bypasses the multiplier. It goes IDLE→DONE with out_valid on the next cycle.
  - Cache invalidated on rst and flush. MULW neither hits nor fills the cache.
- Undefined: every op goes through ISSUE/WAIT, and no cache registers exist.

Decomposition:
- Package mul_ctrl_pkg: op encoding constants, state enum, mul_signed encodings per op.
- Sub-module mul_result_sel: combinational op/hi/lo → out_result, including MULW sign-extend and the illegal-op zero.
- FSM and registers stay in mul_issue_ctrl.

Test Plan:
- MUL, src1=3, src2=5 → mul_signed=11, mulw=0; out_result=15, out_rd echoes the input tag; out_valid held until out_ready.
- MULHU, src1=src2=0xFFFF_FFFF_FFFF_FFFF → mul_signed=00; out_result=0xFFFF_FFFF_FFFF_FFFE.
- MULW, src1=0x7FFF_FFFF, src2=2 → mulw=1; out_result=0xFFFF_FFFF_FFFF_FFFE. MULHSU, src1=-1, src2=2 → out_result=0xFFFF_FFFF_FFFF_FFFF.
- flush in ISSUE and separately on the 2nd WAIT cycle → no out_valid; DRAIN until mul_ready=1; in_ready=1 afterwards; next MUL 7*6 → 42.
- out_ready held low 10 cycles in DONE → out_result/out_rd stable, in_ready=0; no second mul_valid.
- With MUL_CTRL_REUSE_EN: MULH a,b then MUL a,b → second op produces no mul_valid, out_valid one cycle after accept, out_result=lo. Intervening flush → MUL goes through the multiplier.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg
//   Shared definitions for the multiply issue controller: RV64M op
//   encodings as seen on in_op, the controller state enum, and the
//   mul_signed encoding that each op presents to the iterative multiplier.
package mul_ctrl_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  // mul_signed: bit 1 = multiplicand signed, bit 0 = multiplier signed
  localparam logic [1:0] SIGNED_SS = 2'b11;
  localparam logic [1:0] SIGNED_SU = 2'b10;
  localparam logic [1:0] SIGNED_UU = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_MULW);
  endfunction

  function automatic logic [1:0] op_signed(input logic [2:0] op);
    logic [1:0] s;
    case (op)
      OP_MUL, OP_MULH, OP_MULW: s = SIGNED_SS;
      OP_MULHSU:                s = SIGNED_SU;
      default:                  s = SIGNED_UU;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_result_sel.sv
// mul_result_sel
//   Combinational result select for the multiply controller.
//   Ports:
//     op     - in_op encoding of the op being completed
//     hi, lo - upper / lower halves of the 128-bit product
//     result - MUL: lo; MULH/MULHSU/MULHU: hi; MULW: sign-extended lo[31:0];
//              illegal ops: zero
module mul_result_sel #(
  parameter int XLEN = 64
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] result
);
  import mul_ctrl_pkg::*;

  logic signed [31:0] lo_w;

  assign lo_w = lo[31:0];

  always_comb begin
    result = '0;
    case (op)
      OP_MUL:                      result = lo;
      OP_MULH, OP_MULHSU, OP_MULHU: result = hi;
      OP_MULW:                     result = {{(XLEN-32){lo_w[31]}}, lo_w};
      default:                     result = '0;
    endcase
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   EX-stage controller in front of the iterative 64-bit multiplier.
//   Accepts one RV64M multiply op at a time, issues it to the multiplier,
//   waits for the mul_ready completion handshake, selects/sign-extends the
//   result and holds it on a valid/ready writeback port. flush cancels the
//   op in any phase; an op already inside the multiplier is drained and its
//   result discarded.
//   Ports:
//     clk, rst                   - clock, synchronous active-high reset
//     flush                      - cancel in-flight op (also goes to multiplier)
//     in_valid/in_ready          - op request handshake
//     in_op/in_src1/in_src2/in_rd- op code, operands, destination tag
//     mul_valid/mulw/mul_signed  - multiplier request and op qualifiers
//     multiplicand/multiplier    - registered operands to the multiplier
//     mul_ready                  - multiplier idle / result available
//     result_hi/result_lo        - multiplier product halves
//     out_valid/out_ready        - writeback handshake
//     out_result/out_rd          - selected result and its tag
//   Build option:
//     MUL_CTRL_REUSE_EN - caches the last non-MULW product so that a repeat
//                         of the same operands (MUL, or MULH* with matching
//                         signedness) completes without using the multiplier.
module mul_issue_ctrl #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_rd,
  output logic             mul_valid,
  output logic             mulw,
  output logic [1:0]       mul_signed,
  output logic [XLEN-1:0]  multiplicand,
  output logic [XLEN-1:0]  multiplier,
  input  logic             mul_ready,
  input  logic [XLEN-1:0]  result_hi,
  input  logic [XLEN-1:0]  result_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd
);
  import mul_ctrl_pkg::*;

  state_t state, state_nx;

  logic [2:0]       op_r;
  logic [XLEN-1:0]  src1_r;
  logic [XLEN-1:0]  src2_r;
  logic [TAG_W-1:0] rd_r;
  logic             mulw_r;
  logic [1:0]       signed_r;
  logic [XLEN-1:0]  result_r;

  logic             accept;
  logic             reuse_hit;
  logic [2:0]       sel_op;
  logic [XLEN-1:0]  sel_hi;
  logic [XLEN-1:0]  sel_lo;
  logic [XLEN-1:0]  sel_y;

  assign accept = in_valid && in_ready;

`ifdef MUL_CTRL_REUSE_EN
  logic             c_valid;
  logic [XLEN-1:0]  c_hi;
  logic [XLEN-1:0]  c_lo;
  logic [XLEN-1:0]  c_src1;
  logic [XLEN-1:0]  c_src2;
  logic [1:0]       c_signed;

  // MUL's low half does not depend on signedness, so any cached product
  // of the same operands serves it; MULH* needs the same signedness.
  always_comb begin
    reuse_hit = 1'b0;
    if (c_valid && in_src1 == c_src1 && in_src2 == c_src2) begin
      if (in_op == OP_MUL)
        reuse_hit = 1'b1;
      else if ((in_op == OP_MULH || in_op == OP_MULHSU || in_op == OP_MULHU) &&
               op_signed(in_op) == c_signed)
        reuse_hit = 1'b1;
    end
  end

  // In IDLE the selector serves a cache hit; elsewhere it serves the
  // multiplier's completion.
  assign sel_op = (state == ST_IDLE) ? in_op : op_r;
  assign sel_hi = (state == ST_IDLE) ? c_hi  : result_hi;
  assign sel_lo = (state == ST_IDLE) ? c_lo  : result_lo;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      c_valid  <= 1'b0;
      c_hi     <= '0;
      c_lo     <= '0;
      c_src1   <= '0;
      c_src2   <= '0;
      c_signed <= '0;
    end else if (state == ST_WAIT && mul_ready && op_r != OP_MULW) begin
      c_valid  <= 1'b1;
      c_hi     <= result_hi;
      c_lo     <= result_lo;
      c_src1   <= src1_r;
      c_src2   <= src2_r;
      c_signed <= signed_r;
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign sel_op    = op_r;
  assign sel_hi    = result_hi;
  assign sel_lo    = result_lo;
`endif

  mul_result_sel #(.XLEN(XLEN)) u_sel (
    .op     (sel_op),
    .hi     (sel_hi),
    .lo     (sel_lo),
    .result (sel_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state; flush outranks every other condition
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!op_legal(in_op) || reuse_hit) state_nx = ST_DONE;
          else                               state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush)          state_nx = ST_IDLE;
        else if (mul_ready) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)          state_nx = ST_DRAIN;
        else if (mul_ready) state_nx = ST_DONE;
      end
      ST_DRAIN: begin
        if (mul_ready) state_nx = ST_IDLE;
      end
      ST_DONE: begin
        if (flush || out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = 1'b0;
    mul_valid = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE:  in_ready  = !flush && !rst;
      ST_ISSUE: mul_valid = 1'b1;
      ST_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Op / operand / result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= '0;
      src1_r   <= '0;
      src2_r   <= '0;
      rd_r     <= '0;
      mulw_r   <= 1'b0;
      signed_r <= '0;
      result_r <= '0;
    end else begin
      if (state == ST_IDLE && accept) begin
        op_r     <= in_op;
        src1_r   <= in_src1;
        src2_r   <= in_src2;
        rd_r     <= in_rd;
        mulw_r   <= (in_op == OP_MULW);
        signed_r <= op_legal(in_op) ? op_signed(in_op) : SIGNED_UU;
        if (!op_legal(in_op)) result_r <= '0;
        else if (reuse_hit)   result_r <= sel_y;
      end
      if (state == ST_WAIT && !flush && mul_ready)
        result_r <= sel_y;
    end
  end

  assign mulw         = mulw_r;
  assign mul_signed   = signed_r;
  assign multiplicand = src1_r;
  assign multiplier   = src2_r;
  assign out_result   = result_r;
  assign out_rd       = rd_r;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl
//   Directed bench for mul_issue_ctrl with a behavioural iterative
//   multiplier: mul_ready drops on the accept edge, stays low LAT cycles,
//   then rises with the product. An op already inside the multiplier runs
//   to completion regardless of flush, so the controller has to drain it.
//   stall holds mul_ready low while the multiplier is idle.
module tb_mul_issue_ctrl;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  localparam int LAT   = 4;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_src1, in_src2;
  logic [TAG_W-1:0] in_rd;
  logic             mul_valid, mulw;
  logic [1:0]       mul_signed;
  logic [XLEN-1:0]  multiplicand, multiplier;
  logic             mul_ready;
  logic [XLEN-1:0]  result_hi, result_lo;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .mul_valid(mul_valid), .mulw(mulw), .mul_signed(mul_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_ready(mul_ready), .result_hi(result_hi), .result_lo(result_lo),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd)
  );

  // Behavioural multiplier
  logic        m_ready_int;
  int          m_cnt;
  int          starts;
  logic [63:0] p_hi, p_lo;
  logic        stall;

  assign mul_ready = m_ready_int && !stall;

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] sg, input logic w);
    logic [127:0] ea, eb;
    if (w) begin
      ea = {{96{a[31]}}, a[31:0]};
      eb = {{96{b[31]}}, b[31:0]};
    end else begin
      ea = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
      eb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
    end
    return ea * eb;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready_int <= 1'b1;
      m_cnt       <= 0;
      result_hi   <= '0;
      result_lo   <= '0;
      starts      <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_ready_int <= 1'b1;
      m_cnt       <= 0;
      result_hi   <= p_hi;
      result_lo   <= p_lo;
    end else if (mul_valid && mul_ready && !flush) begin
      m_ready_int <= 1'b0;
      m_cnt       <= LAT;
      {p_hi, p_lo} <= ref_mul(multiplicand, multiplier, mul_signed, mulw);
      starts      <= starts + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    in_op = op; in_src1 = a; in_src2 = b; in_rd = rd; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    check({tag, "_done"}, 64'(out_valid), 64'd1);
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] RA   = 64'h0000_0001_0000_0000;
  localparam logic [63:0] RB   = 64'h0000_0003_0000_0005;

  initial begin
    int n, s;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_src1 = '0; in_src2 = '0; in_rd = '0; out_ready = 1'b0; stall = 1'b0;
    step(); step();
    check("rst_in_ready",   64'(in_ready),   64'd0);
    check("rst_mul_valid",  64'(mul_valid),  64'd0);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_mulw",       64'(mulw),       64'd0);
    check("rst_mul_signed", 64'(mul_signed), 64'd0);
    check("rst_mcand",      multiplicand,    64'd0);
    check("rst_result",     out_result,      64'd0);
    check("rst_rd",         64'(out_rd),     64'd0);
    rst = 1'b0;
    step();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // MUL 3*5
    s = starts;
    drive(OP_MUL, 64'd3, 64'd5, 5'd9);
    check("mul_mul_valid", 64'(mul_valid),  64'd1);
    check("mul_mulw",      64'(mulw),       64'd0);
    check("mul_signed",    64'(mul_signed), 64'd3);
    check("mul_mcand",     multiplicand,    64'd3);
    check("mul_mplier",    multiplier,      64'd5);
    check("mul_in_ready",  64'(in_ready),   64'd0);
    wait_out("mul", n);
    check("mul_latency",   64'(n),          64'(2 + LAT));
    check("mul_result",    out_result,      64'd15);
    check("mul_rd",        64'(out_rd),     64'd9);
    repeat (3) step();
    check("mul_hold_valid",  64'(out_valid), 64'd1);
    check("mul_hold_result", out_result,     64'd15);
    finish_out();
    check("mul_out_drop",  64'(out_valid),  64'd0);
    check("mul_in_ready2", 64'(in_ready),   64'd1);
    check("mul_starts",    64'(starts - s), 64'd1);

    // MULHU all-ones
    drive(OP_MULHU, ONES, ONES, 5'd1);
    check("mulhu_signed", 64'(mul_signed), 64'd0);
    wait_out("mulhu", n);
    check("mulhu_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    finish_out();

    // MULW 0x7FFFFFFF*2
    drive(OP_MULW, 64'h7FFF_FFFF, 64'd2, 5'd2);
    check("mulw_mulw",   64'(mulw),       64'd1);
    check("mulw_signed", 64'(mul_signed), 64'd3);
    wait_out("mulw", n);
    check("mulw_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    finish_out();

    // MULHSU -1 * 2
    drive(OP_MULHSU, ONES, 64'd2, 5'd3);
    check("mulhsu_signed", 64'(mul_signed), 64'd2);
    wait_out("mulhsu", n);
    check("mulhsu_result", out_result, ONES);
    finish_out();

    // Illegal op completes without the multiplier
    s = starts;
    drive(3'd5, 64'd9, 64'd9, 5'd17);
    check("ill_out_valid", 64'(out_valid),  64'd1);
    check("ill_mul_valid", 64'(mul_valid),  64'd0);
    check("ill_result",    out_result,      64'd0);
    check("ill_rd",        64'(out_rd),     64'd17);
    finish_out();
    check("ill_starts",    64'(starts - s), 64'd0);

    // Held in ISSUE, then flushed there
    s = starts;
    stall = 1'b1;
    drive(OP_MUL, 64'd11, 64'd13, 5'd4);
    repeat (3) step();
    check("iss_hold_valid", 64'(mul_valid), 64'd1);
    check("iss_hold_mcand", multiplicand,   64'd11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    #1;
    check("iss_fl_mul_valid", 64'(mul_valid),  64'd0);
    check("iss_fl_out_valid", 64'(out_valid),  64'd0);
    check("iss_fl_in_ready",  64'(in_ready),   64'd1);
    check("iss_fl_starts",    64'(starts - s), 64'd0);

    // Flush on the second WAIT cycle, drain
    drive(OP_MUL, 64'd11, 64'd13, 5'd4);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("wt_fl_out_valid", 64'(out_valid), 64'd0);
    check("wt_fl_in_ready",  64'(in_ready),  64'd0);
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
      check("drain_out_valid", 64'(out_valid), 64'd0);
    end
    check("drain_cycles",  64'(n),          64'd3);
    check("drain_starts",  64'(starts - s), 64'd1);

    // MUL 7*6 then hold in DONE while a new request is offered
    s = starts;
    drive(OP_MUL, 64'd7, 64'd6, 5'd3);
    wait_out("m76", n);
    check("m76_result", out_result, 64'd42);
    in_op = OP_MUL; in_src1 = 64'd1; in_src2 = 64'd1; in_rd = 5'd7; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("dn_out_valid", 64'(out_valid), 64'd1);
      check("dn_result",    out_result,     64'd42);
      check("dn_rd",        64'(out_rd),    64'd3);
      check("dn_in_ready",  64'(in_ready),  64'd0);
      check("dn_mul_valid", 64'(mul_valid), 64'd0);
    end
    in_valid = 1'b0;
    finish_out();
    check("dn_starts", 64'(starts - s), 64'd1);

    // Repeated operands: MULH then MUL
    drive(OP_MULH, RA, RB, 5'd10);
    wait_out("rh", n);
    check("rh_result", out_result, 64'd3);
    finish_out();
    s = starts;
    drive(OP_MUL, RA, RB, 5'd11);
`ifdef MUL_CTRL_REUSE_EN
    check("hit_out_valid", 64'(out_valid),  64'd1);
    check("hit_mul_valid", 64'(mul_valid),  64'd0);
    check("hit_result",    out_result,      64'h0000_0005_0000_0000);
    check("hit_rd",        64'(out_rd),     64'd11);
    finish_out();
    check("hit_starts",    64'(starts - s), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    drive(OP_MUL, RA, RB, 5'd12);
    check("miss_mul_valid", 64'(mul_valid), 64'd1);
    wait_out("miss", n);
    check("miss_result", out_result, 64'h0000_0005_0000_0000);
    finish_out();
    check("miss_starts", 64'(starts - s), 64'd1);
`else
    check("rm_mul_valid", 64'(mul_valid), 64'd1);
    wait_out("rm", n);
    check("rm_result", out_result, 64'h0000_0005_0000_0000);
    finish_out();
    check("rm_starts", 64'(starts - s), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
